// File: rtl/decay_scheduler_pkg.sv
// Shared definitions for the decay scheduler: decay-mode encodings,
// FSM state encoding and a helper that identifies modes needing no sweep.
package decay_scheduler_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MODE_LIF0  = 3'd0,
    MODE_LIF2  = 3'd1,
    MODE_LIF4  = 3'd2,
    MODE_LIF8  = 3'd3,
    MODE_LIF24 = 3'd4,
    MODE_IZHI  = 3'd5,
    MODE_QUAD  = 3'd6,
    MODE_IDLE  = 3'd7
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAPT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WR    = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  // LIF0 leaves potentials untouched and IDLE disables decay, so neither
  // needs a memory sweep.
  function automatic logic is_skip_mode(input logic [2:0] m);
    return (m == MODE_LIF0) || (m == MODE_IDLE);
  endfunction

endpackage

// File: rtl/decay_scheduler_watchdog.sv
// WAIT-state cycle counter for the decay scheduler. Only built when the
// DECAY_TIMEOUT_EN macro is defined; otherwise this file is empty.
`ifdef DECAY_TIMEOUT_EN
module decay_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive WAIT cycles; any cycle outside WAIT restarts the count.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT_CYC-th consecutive WAIT cycle.
  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/decay_scheduler.sv
// Decay scheduler: on each time_step pulse, sweeps every neuron potential
// through the shared decay unit (read, issue, wait, write back).
// Optional feature macro: DECAY_TIMEOUT_EN (WAIT watchdog + timeout_err).
module decay_scheduler
  import decay_scheduler_pkg::*;
#(
  parameter int NEURON_CNT  = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              time_step,
  input  logic [2:0]        mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              dec_start,
  output logic [2:0]        dec_mode,
  output logic [31:0]       dec_potential,
  input  logic              dec_done,
  input  logic [31:0]       dec_result,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURON_CNT - 1);

  state_t                    state_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [2:0]                mode_q;
  logic signed [DATA_W-1:0]  pot_q;
  logic signed [DATA_W-1:0]  res_q;
  logic                      mem_rd_en_q;
  logic                      mem_wr_en_q;
  logic                      dec_start_q;
  logic                      sweep_done_q;
  logic                      overrun_q;

  logic at_last;
  logic restart_ok;
  logic start_req;

  assign at_last    = (addr_q == LAST_ADDR);
  // A new request is accepted while idle or in the final NEXT cycle, which
  // is the cycle that carries sweep_done.
  assign restart_ok = (state_q == ST_IDLE) || ((state_q == ST_NEXT) && at_last);
  assign start_req  = time_step && restart_ok;

`ifdef DECAY_TIMEOUT_EN
  logic wd_run;
  logic wd_expired;
  logic timeout_q;

  assign wd_run = (state_q == ST_WAIT);

  decay_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (wd_run),
    .expired (wd_expired)
  );

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Sweep FSM with registered one-cycle strobes and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mode_q       <= '0;
      pot_q        <= '0;
      res_q        <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef DECAY_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;

      if (time_step && !restart_ok) begin
        overrun_q <= 1'b1;
      end

      if (start_req) begin
        mode_q <= mode;
        addr_q <= '0;
        if (is_skip_mode(mode)) begin
          sweep_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end else begin
          mem_rd_en_q <= 1'b1;
          state_q     <= ST_RD;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_RD: begin
            state_q <= ST_CAPT;
          end
          ST_CAPT: begin
            pot_q       <= mem_rd_data;
            dec_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
          ST_ISSUE: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (dec_done) begin
              res_q       <= dec_result;
              mem_wr_en_q <= 1'b1;
              state_q     <= ST_WR;
            end
`ifdef DECAY_TIMEOUT_EN
            else if (wd_expired) begin
              res_q       <= pot_q;
              timeout_q   <= 1'b1;
              mem_wr_en_q <= 1'b1;
              state_q     <= ST_WR;
            end
`endif
          end
          ST_WR: begin
            if (at_last) begin
              sweep_done_q <= 1'b1;
            end
            state_q <= ST_NEXT;
          end
          ST_NEXT: begin
            if (at_last) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q      <= addr_q + 1'b1;
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_RD;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd_en     = mem_rd_en_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign dec_start     = dec_start_q;
  assign sweep_done    = sweep_done_q;
  assign overrun       = overrun_q;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = res_q;
  assign dec_mode      = mode_q;
  assign dec_potential = pot_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decay_scheduler.sv
// Self-checking bench for decay_scheduler: memory model, x>>1 decay stub
// with a fixed 3-cycle answer delay, and a write/mode scoreboard.
module tb_decay_scheduler;
  import decay_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int TO  = 8;
  localparam int K   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          time_step;
  logic [2:0]    mode;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rd_data = '0;
  logic          mem_wr_en;
  logic [31:0]   mem_wr_data;
  logic          dec_start;
  logic [2:0]    dec_mode;
  logic [31:0]   dec_potential;
  logic          dec_done = 1'b0;
  logic [31:0]   dec_result = '0;
  logic          busy;
  logic          sweep_done;
  logic          overrun;
  logic          timeout_err;

  decay_scheduler #(
    .NEURON_CNT (N),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .time_step    (time_step),
    .mode         (mode),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .dec_start    (dec_start),
    .dec_mode     (dec_mode),
    .dec_potential(dec_potential),
    .dec_done     (dec_done),
    .dec_result   (dec_result),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: registered read, write on mem_wr_en, bulk load from bench.
  logic [31:0] mem [N];
  logic [31:0] load_vals [N];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= load_vals[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Decay stub: answers x>>1 exactly K cycles after the dec_start cycle,
  // unless the neuron address matches silent_addr. Ignores rst on purpose.
  logic        stub_pend = 1'b0;
  int          stub_cnt  = 0;
  logic [31:0] stub_pot  = '0;
  int          silent_addr = -1;

  always @(posedge clk) begin
    dec_done <= 1'b0;
    if (stub_pend) begin
      if (stub_cnt <= 1) begin
        dec_done   <= 1'b1;
        dec_result <= stub_pot >> 1;
        stub_pend  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
    if (dec_start && (int'(mem_addr) != silent_addr)) begin
      stub_pend <= 1'b1;
      stub_cnt  <= K - 1;
      stub_pot  <= dec_potential;
    end
  end

  // Scoreboard queues filled when a sweep is requested.
  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [2:0]  exp_md[$];
  logic [31:0] ref_mem [N];

  int wr_cnt = 0;
  int rd_cnt = 0;
  int sd_cnt = 0;
  int sd_cyc = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    chk("strobe_excl", 32'(mem_rd_en) + 32'(mem_wr_en) + 32'(dec_start) > 1, 0);
    if (mem_rd_en) rd_cnt++;
    if (sweep_done) begin
      sd_cnt++;
      sd_cyc = cyc;
    end
    if (mem_wr_en) begin
      wr_cnt++;
      if (exp_wa.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
        chk("wr_data", mem_wr_data, exp_wd.pop_front());
      end
    end
    if (dec_start) begin
      if (exp_md.size() == 0) begin
        chk("unexpected_dec_start", 1, 0);
      end else begin
        chk("dec_mode", 32'(dec_mode), 32'(exp_md.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < N; i++) begin
      load_vals[i] = 32'(100 * (i + 1));
      ref_mem[i]   = 32'(100 * (i + 1));
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic exp_sweep(input int n_wr, input int n_st, input logic [2:0] m, input int silent);
    logic [31:0] v;
    for (int a = 0; a < n_st; a++) exp_md.push_back(m);
    for (int a = 0; a < n_wr; a++) begin
      v = (a == silent) ? ref_mem[a] : (ref_mem[a] >> 1);
      ref_mem[a] = v;
      exp_wa.push_back(a);
      exp_wd.push_back(v);
    end
  endtask

  task automatic pulse_ts();
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
  endtask

  task automatic wait_done(input int sd0, input int lim);
    int n;
    n = 0;
    while (sd_cnt == sd0 && n < lim) begin
      tick();
      n++;
    end
    chk("sweep_done_seen", 32'(sd_cnt != sd0), 1);
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < N; i++) chk(tag, mem[i], ref_mem[i]);
  endtask

  int c0, sd0, wr0, rd0;

  initial begin
    rst = 1'b1;
    time_step = 1'b0;
    mode = MODE_LIF0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sweep_done", 32'(sweep_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    tick();

    // Basic sweep, LIF2.
    load_mem();
    mode = MODE_LIF2;
    exp_sweep(N, N, MODE_LIF2, -1);
    sd0 = sd_cnt; wr0 = wr_cnt;
    c0 = cyc;
    pulse_ts();
    chk("basic_busy", 32'(busy), 1);
    wait_done(sd0, 100);
    chk("basic_latency", 32'(sd_cyc - c0), 32);
    repeat (5) tick();
    chk("basic_sd_count", 32'(sd_cnt - sd0), 1);
    chk("basic_writes", 32'(wr_cnt - wr0), N);
    chk_mem("basic_mem");

    // Skip modes.
    for (int s = 0; s < 2; s++) begin
      mode = (s == 0) ? MODE_LIF0 : MODE_IDLE;
      sd0 = sd_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
      c0 = cyc;
      pulse_ts();
      repeat (4) tick();
      chk("skip_sd_count", 32'(sd_cnt - sd0), 1);
      chk("skip_sd_latency", 32'(sd_cyc - c0), 1);
      chk("skip_reads", 32'(rd_cnt - rd0), 0);
      chk("skip_writes", 32'(wr_cnt - wr0), 0);
      chk("skip_busy", 32'(busy), 0);
    end

    // Overrun: second request 5 cycles into the sweep.
    load_mem();
    mode = MODE_LIF2;
    exp_sweep(N, N, MODE_LIF2, -1);
    sd0 = sd_cnt; wr0 = wr_cnt;
    c0 = cyc;
    pulse_ts();
    while (cyc < c0 + 5) tick();
    pulse_ts();
    chk("ovr_flag", 32'(overrun), 1);
    wait_done(sd0, 100);
    repeat (40) tick();
    chk("ovr_sd_count", 32'(sd_cnt - sd0), 1);
    chk("ovr_writes", 32'(wr_cnt - wr0), N);
    chk_mem("ovr_mem");

    // Reset during WAIT of neuron 2.
    load_mem();
    mode = MODE_LIF2;
    exp_sweep(2, 3, MODE_LIF2, -1);
    wr0 = wr_cnt;
    c0 = cyc;
    pulse_ts();
    while (cyc < c0 + 20) tick();
    chk("mrst_in_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    chk("mrst_timeout", 32'(timeout_err), 0);
    chk("mrst_rd_en", 32'(mem_rd_en), 0);
    chk("mrst_wr_en", 32'(mem_wr_en), 0);
    chk("mrst_dec_start", 32'(dec_start), 0);
    chk("mrst_sweep_done", 32'(sweep_done), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    chk("mrst_dec_mode", 32'(dec_mode), 0);
    chk("mrst_dec_pot", dec_potential, 0);
    chk("mrst_wr_data", mem_wr_data, 0);
    repeat (8) tick();
    chk("mrst_late_busy", 32'(busy), 0);
    chk("mrst_writes", 32'(wr_cnt - wr0), 2);
    chk_mem("mrst_mem");

    // Back-to-back sweeps, IZHI then QUAD; mode changed mid-sweep.
    load_mem();
    mode = MODE_IZHI;
    exp_sweep(N, N, MODE_IZHI, -1);
    c0 = cyc;
    pulse_ts();
    while (cyc < c0 + 10) tick();
    mode = MODE_QUAD;
    while (cyc < c0 + 32) tick();
    chk("b2b_sd_first", 32'(sweep_done), 1);
    exp_sweep(N, N, MODE_QUAD, -1);
    pulse_ts();
    chk("b2b_restart_rd", 32'(mem_rd_en), 1);
    chk("b2b_restart_addr", 32'(mem_addr), 0);
    chk("b2b_dec_mode_reg", 32'(dec_mode), 6);
    sd0 = sd_cnt;
    wait_done(sd0, 100);
    chk("b2b_latency", 32'(sd_cyc - (c0 + 32)), 32);
    chk("b2b_no_overrun", 32'(overrun), 0);
    repeat (3) tick();
    chk_mem("b2b_mem");

`ifdef DECAY_TIMEOUT_EN
    // Stub stays silent for neuron 1.
    load_mem();
    mode = MODE_LIF2;
    silent_addr = 1;
    exp_sweep(N, N, MODE_LIF2, 1);
    sd0 = sd_cnt;
    pulse_ts();
    wait_done(sd0, 200);
    repeat (3) tick();
    silent_addr = -1;
    chk("to_flag", 32'(timeout_err), 1);
    chk("to_mem1", mem[1], 200);
    chk_mem("to_mem");
`else
    chk("to_tied", 32'(timeout_err), 0);
`endif

    repeat (3) tick();
    chk("wq_empty", 32'(exp_wa.size()), 0);
    chk("mq_empty", 32'(exp_md.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decay_scheduler.md
DECAY_SCHEDULER -- requirements
Module: decay_scheduler

Interface
REQ-001 Parameter NEURON_CNT, default 32: number of neurons swept per time step (1..2^ADDR_W).
REQ-002 Parameter ADDR_W, default 5: potential-memory address width.
REQ-003 Parameter TIMEOUT_CYC, default 64: watchdog limit in cycles for dec_done (used only with DECAY_TIMEOUT_EN).
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Port time_step, input, 1: one-cycle pulse that requests a decay sweep.
REQ-007 Port mode, input, 3: global decay mode, sampled at sweep start.
REQ-008 Ports mem_rd_en (output, 1), mem_addr (output, ADDR_W) and mem_rd_data (input, 32): potential memory read; data is valid one cycle after mem_rd_en.
REQ-009 Ports mem_wr_en (output, 1) and mem_wr_data (output, 32): write-back to mem_addr.
REQ-010 Ports dec_start (output, 1), dec_mode (output, 3) and dec_potential (output, 32): request to the shared decay unit.
REQ-011 Ports dec_done (input, 1) and dec_result (input, 32): decay unit completion; dec_result is valid while dec_done is high.
REQ-012 Ports busy (output, 1), sweep_done (output, 1 pulse), overrun (output, 1 sticky) and timeout_err (output, 1 sticky): status.

Function
REQ-013 FSM states SHALL be IDLE, RD, CAPT, ISSUE, WAIT, WR and NEXT.
REQ-014 IDLE: on time_step, latch mode into mode_q and clear addr to 0.
  - mode_q = IDLE or LIF0: no memory access; pulse sweep_done the next cycle and remain in IDLE.
  - Otherwise: go to RD.
REQ-015 RD: assert mem_rd_en for one cycle with mem_addr = addr.
REQ-016 CAPT: register mem_rd_data into pot_q.
REQ-017 ISSUE: assert dec_start for exactly one cycle, with dec_potential = pot_q and dec_mode = mode_q.
REQ-018 WAIT: hold until dec_done = 1, then register dec_result.
  - dec_done asserted outside WAIT SHALL be ignored.
REQ-019 WR: assert mem_wr_en for one cycle with mem_wr_data = registered result and mem_addr = addr.
REQ-020 NEXT: if addr = NEURON_CNT-1, pulse sweep_done and go to IDLE; else increment addr and go to RD.
REQ-021 Per-neuron latency SHALL be 4+k cycles, where dec_done arrives k>=1 cycles after the ISSUE cycle.
  - Sweep latency SHALL be NEURON_CNT*(5+k) cycles, including NEXT.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 A time_step while busy SHALL set overrun; the sweep continues and the request is dropped.
REQ-024 A time_step coincident with the sweep_done cycle SHALL start a new sweep on the next cycle.
REQ-025 mode changes during a sweep SHALL have no effect until the next sweep.
REQ-026 mem_rd_en, mem_wr_en and dec_start SHALL be mutually exclusive in every cycle.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and addr, pot_q, mode_q and all outputs SHALL be 0, including overrun and timeout_err.
REQ-028 rst mid-sweep SHALL abort with no further memory write; a late dec_done after reset SHALL be ignored.

Configuration
REQ-029 Macro DECAY_TIMEOUT_EN defined: a WAIT counter runs.
  - Reaching TIMEOUT_CYC without dec_done sets timeout_err.
  - pot_q is written back unchanged and the sweep proceeds to the next neuron.
REQ-030 Macro DECAY_TIMEOUT_EN undefined: WAIT has no limit and timeout_err is tied to 0.

Structure
REQ-031 The shared package SHALL hold the mode encodings: LIF0=0, LIF2=1, LIF4=2, LIF8=3, LIF24=4, IZHI=5, QUAD=6, IDLE=7.
REQ-032 The shared package SHALL also hold the FSM state encoding.
REQ-033 One sub-module, decay_watchdog (WAIT cycle counter with expiry flag), SHALL be instantiated only under DECAY_TIMEOUT_EN.

Verification
REQ-034 Basic sweep: NEURON_CNT=4, memory {100,200,300,400}, mode LIF2, stub returns x>>1 with k=3.
  - Required: memory becomes {50,100,150,200}.
  - Required: one sweep_done, 32 cycles after the time_step.
REQ-035 Skip modes: mode=LIF0 or mode=IDLE, then time_step.
  - Required: no mem_rd_en or mem_wr_en, and sweep_done one cycle later.
REQ-036 Overrun: second time_step 5 cycles into a sweep.
  - Required: overrun=1, exactly 4 writes, one sweep_done.
REQ-037 Mid-sweep reset: rst during WAIT of neuron 2.
  - Required: neuron 2 and later unmodified, all outputs 0, and a stub dec_done after reset ignored.
REQ-038 Timeout, with DECAY_TIMEOUT_EN and TIMEOUT_CYC=8: stub never answers for neuron 1 (value 200).
  - Required: timeout_err=1, memory[1] stays 200, and the sweep completes.
REQ-039 Back-to-back sweeps: time_step coincident with sweep_done, mode changed IZHI->QUAD between sweeps.
  - Required: the second sweep starts the next cycle with dec_mode=6 throughout.
